hazard_forward_unit: RTL

Pipeline hazard controller for the five-stage RV32I core. It tracks the destination register and the write/load flags of the instructions in EX, MEM and WB, and drives the 2-bit selects of the two EX-stage operand 3-input muxes (forwarding). It also generates the IF/ID stall and the EX-bubble/ID-flush controls for load-use hazards and taken branches. It sits beside the ID/EX boundary and directly feeds the `sel` inputs of the operand muxes.

---
 rtl/hazard_forward_unit_pkg.sv | 28 ++
 rtl/hazard_forward_unit_if.sv | 46 ++++
 rtl/hazard_forward_unit_fwd_select.sv | 24 ++
 rtl/hazard_forward_unit.sv | 98 +++++++++
 4 files changed

// File: rtl/hazard_forward_unit_pkg.sv
// Shared RV32I pipeline types: operand forward selects and per-stage control.
// Provides fwd_sel_e, stage_ctl_t and the writes_reg producer-match helper.
package rv_pkg;

    localparam int RV_REG_W = 5;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic                valid;
        logic [RV_REG_W-1:0] rd;
        logic                reg_write;
        logic                mem_read;
    } stage_ctl_t;

    // True when stage s will write register r (x0 never counts).
    function automatic logic writes_reg(
        stage_ctl_t          s,
        logic [RV_REG_W-1:0] r
    );
        return s.valid & s.reg_write & (s.rd != '0) & (s.rd == r);
    endfunction

endpackage

// File: rtl/hazard_forward_unit_if.sv
// ID-side request and hazard/forward response bundle of hazard_forward_unit.
// master: pipeline drives ID fields and branch; slave: hazard unit drives controls.
interface hazard_forward_unit_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_use_rs1;
    logic                  id_use_rs2;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_reg_write;
    logic                  id_mem_read;
    logic                  ex_branch_taken;
    logic [1:0]            forward_a;
    logic [1:0]            forward_b;
    logic                  stall_if;
    logic                  stall_id;
    logic                  flush_id;
    logic                  flush_ex;
    logic [CNT_W-1:0]      stall_cycles;
    logic [CNT_W-1:0]      flush_count;

    modport master (
        output id_valid, id_rs1, id_rs2,
        output id_use_rs1, id_use_rs2,
        output id_rd, id_reg_write, id_mem_read,
        output ex_branch_taken,
        input  forward_a, forward_b,
        input  stall_if, stall_id,
        input  flush_id, flush_ex,
        input  stall_cycles, flush_count
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2,
        input  id_use_rs1, id_use_rs2,
        input  id_rd, id_reg_write, id_mem_read,
        input  ex_branch_taken,
        output forward_a, forward_b,
        output stall_if, stall_id,
        output flush_id, flush_ex,
        output stall_cycles, flush_count
    );
endinterface

// File: rtl/hazard_forward_unit_fwd_select.sv
// One EX operand mux select; MEM beats WB so the youngest value wins.
// Ports: rs/rs_used (EX source), mem/wb (producer ctl), sel (mux select).
module fwd_select
    import rv_pkg::*;
(
    input  logic [RV_REG_W-1:0] rs,
    input  logic                rs_used,
    input  stage_ctl_t          mem,
    input  stage_ctl_t          wb,
    output fwd_sel_e            sel
);

    logic unused_load_bits;
    assign unused_load_bits = mem.mem_read ^ wb.mem_read;

    always_comb begin
        sel = FWD_REG;
        if (rs_used & writes_reg(mem, rs))
            sel = FWD_MEM;
        else if (rs_used & writes_reg(wb, rs))
            sel = FWD_WB;
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Load-use stall, branch flush and EX operand forwarding for the 5-stage core.
// Ports: clk, rst (sync, active high), bus (slave side of hazard_forward_unit_if).
module hazard_forward_unit
    import rv_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input logic                  clk,
    input logic                  rst,
    hazard_forward_unit_if.slave bus
);

    stage_ctl_t            ex_ctl;
    stage_ctl_t            mem_ctl;
    stage_ctl_t            wb_ctl;
    logic [REG_ADDR_W-1:0] ex_rs1;
    logic [REG_ADDR_W-1:0] ex_rs2;
    logic                  ex_use_rs1;
    logic                  ex_use_rs2;
    logic [CNT_W-1:0]      stall_cnt;
    logic [CNT_W-1:0]      flush_cnt;

    logic     ex_load;
    logic     lu;
    logic     stall;
    logic     flush_ex;
    fwd_sel_e sel_a;
    fwd_sel_e sel_b;

    assign ex_load = ex_ctl.valid & ex_ctl.mem_read
                   & (ex_ctl.rd != '0);

    assign lu = ex_load & bus.id_valid
              & ((bus.id_use_rs1 & (bus.id_rs1 == ex_ctl.rd))
               | (bus.id_use_rs2 & (bus.id_rs2 == ex_ctl.rd)));

    // A taken branch kills the consumer anyway, so it overrides the stall.
    assign stall    = lu & ~bus.ex_branch_taken & ~rst;
    assign flush_ex = (lu | bus.ex_branch_taken) & ~rst;

    assign bus.stall_if     = stall;
    assign bus.stall_id     = stall;
    assign bus.flush_id     = bus.ex_branch_taken & ~rst;
    assign bus.flush_ex     = flush_ex;
    assign bus.stall_cycles = stall_cnt;
    assign bus.flush_count  = flush_cnt;

    fwd_select u_fwd_a (
        .rs      (ex_rs1),
        .rs_used (ex_use_rs1),
        .mem     (mem_ctl),
        .wb      (wb_ctl),
        .sel     (sel_a)
    );

    fwd_select u_fwd_b (
        .rs      (ex_rs2),
        .rs_used (ex_use_rs2),
        .mem     (mem_ctl),
        .wb      (wb_ctl),
        .sel     (sel_b)
    );

    assign bus.forward_a = rst ? 2'(FWD_REG) : 2'(sel_a);
    assign bus.forward_b = rst ? 2'(FWD_REG) : 2'(sel_b);

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_ctl     <= '0;
            mem_ctl    <= '0;
            wb_ctl     <= '0;
            ex_rs1     <= '0;
            ex_rs2     <= '0;
            ex_use_rs1 <= 1'b0;
            ex_use_rs2 <= 1'b0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
        end else begin
            wb_ctl  <= mem_ctl;
            mem_ctl <= ex_ctl;
            // A bubble keeps the ID fields but can never write or load.
            ex_ctl.valid     <= bus.id_valid & ~flush_ex;
            ex_ctl.rd        <= bus.id_rd;
            ex_ctl.reg_write <= bus.id_reg_write & ~flush_ex;
            ex_ctl.mem_read  <= bus.id_mem_read & ~flush_ex;
            ex_rs1     <= bus.id_rs1;
            ex_rs2     <= bus.id_rs2;
            ex_use_rs1 <= bus.id_use_rs1;
            ex_use_rs2 <= bus.id_use_rs2;
            if (stall && !(&stall_cnt))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (bus.ex_branch_taken && !(&flush_cnt))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule
